// File: rtl/ysyx_23060025_lsu_mem_responder.sv
// Responder end of the LSU load/store bus: word-organised SRAM with a fixed
// access latency, byte-lane stores, and error flagging for bad accesses.
module ysyx_23060025_lsu_mem_responder #(
  parameter int unsigned          ADDR_LEN    = 32,
  parameter int unsigned          DATA_LEN    = 32,
  parameter int unsigned          DEPTH_WORDS = 1024,
  parameter logic [ADDR_LEN-1:0]  BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned          LATENCY     = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_LEN-1:0] in_paddr,
  input  logic                in_psel,
  input  logic                in_pwrite,
  input  logic [2:0]          in_psize,
  input  logic [DATA_LEN-1:0] in_pwdata,
  input  logic [3:0]          in_pwstrb,
  output logic [DATA_LEN-1:0] in_prdata,
  output logic                in_pvalid,
  output logic                in_perr
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_LEN-1:0] r_paddr;
  logic                r_pwrite;
  logic [2:0]          r_psize;
  logic [DATA_LEN-1:0] r_pwdata;
  logic [3:0]          r_pwstrb;
  logic [DATA_LEN-1:0] r_prdata;
  logic                r_pvalid;
  logic                r_perr;
  logic [DATA_LEN-1:0] r_mem [DEPTH_WORDS];

  logic                w_use_in;
  logic [ADDR_LEN-1:0] w_paddr;
  logic                w_pwrite;
  logic [2:0]          w_psize;
  logic [DATA_LEN-1:0] w_pwdata;
  logic [3:0]          w_pwstrb;
  logic [ADDR_LEN-1:0] w_off;
  logic [IDX_W-1:0]    w_idx;
  logic                w_err;
  logic                w_commit;

  // With LATENCY==1 the capture edge is also the commit edge, so the commit
  // path has to see the live inputs instead of the (not yet loaded) registers.
  assign w_use_in = (r_state == S_IDLE);
  assign w_paddr  = w_use_in ? in_paddr  : r_paddr;
  assign w_pwrite = w_use_in ? in_pwrite : r_pwrite;
  assign w_psize  = w_use_in ? in_psize  : r_psize;
  assign w_pwdata = w_use_in ? in_pwdata : r_pwdata;
  assign w_pwstrb = w_use_in ? in_pwstrb : r_pwstrb;

  assign w_off = w_paddr - BASE_ADDR;
  assign w_idx = w_off[IDX_W+1:2];

  always_comb begin
    w_err = 1'b0;
    if (w_paddr < BASE_ADDR)                        w_err = 1'b1;
    if ((w_off >> (IDX_W + 2)) != '0)               w_err = 1'b1;
    if (w_psize == 3'b001 && w_paddr[0])            w_err = 1'b1;
    if (w_psize == 3'b010 && w_paddr[1:0] != 2'b00) w_err = 1'b1;
    if (w_psize > 3'b010)                           w_err = 1'b1;
  end

  always_comb begin
    w_commit = 1'b0;
    if (!reset) begin
      if (r_state == S_IDLE && in_psel && LATENCY == 1) w_commit = 1'b1;
      if (r_state == S_BUSY && r_cnt == 4'd1)           w_commit = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_commit && w_pwrite && !w_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_pwstrb[i]) r_mem[w_idx][8*i +: 8] <= w_pwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_psize  <= '0;
      r_pwdata <= '0;
      r_pwstrb <= '0;
      r_prdata <= '0;
      r_pvalid <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_pvalid <= 1'b0;
      if (w_commit) begin
        r_pvalid <= 1'b1;
        r_perr   <= w_err;
        if (w_err)          r_prdata <= '0;
        else if (!w_pwrite) r_prdata <= r_mem[w_idx];
      end
      case (r_state)
        S_IDLE: begin
          if (in_psel) begin
            r_paddr  <= in_paddr;
            r_pwrite <= in_pwrite;
            r_psize  <= in_psize;
            r_pwdata <= in_pwdata;
            r_pwstrb <= in_pwstrb;
            if (LATENCY == 1) begin
              r_cnt   <= '0;
              r_state <= S_RESP;
            end else begin
              r_cnt   <= CNT_INIT;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_prdata = r_prdata;
  assign in_pvalid = r_pvalid;
  assign in_perr   = r_perr;

endmodule
